// File: rtl/p1v_clk_pkg.sv
// Shared definitions for the CLKSET sequencer: CLK register bit positions,
// sequencer states and CLKSEL encodings.
package p1v_clk_pkg;

    localparam int unsigned CLK_RESET   = 7;
    localparam int unsigned CLK_PLLENA  = 6;
    localparam int unsigned CLK_OSCENA  = 5;
    localparam int unsigned CLK_OSCM_HI = 4;
    localparam int unsigned CLK_OSCM_LO = 3;
    localparam int unsigned CLK_SEL_HI  = 2;
    localparam int unsigned CLK_SEL_LO  = 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENABLE = 3'd1,
        SETTLE = 3'd2,
        APPLY  = 3'd3,
        RESET  = 3'd4
    } clkseq_state_t;

    typedef enum logic [2:0] {
        RCFAST  = 3'd0,
        RCSLOW  = 3'd1,
        XINPUT  = 3'd2,
        PLL1X   = 3'd3,
        PLL2X   = 3'd4,
        PLL4X   = 3'd5,
        PLL8X   = 3'd6,
        PLL16X  = 3'd7
    } clksel_t;

endpackage

// File: rtl/clkseq_timer.sv
// Loadable down-counter with zero flag, shared by the SETTLE and RESET phases.
module clkseq_timer #(
    parameter int unsigned Width = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clkset_sequencer.sv
// CLKSET sequencer: owns the clock generator config and orders enable/settle/switch.
// Define CLKSEQ_SETTLE_EN to wait SETTLE_CYCLES after a source enable rises.
module clkset_sequencer
    import p1v_clk_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1600000,
    parameter int unsigned RESET_CYCLES  = 16,
    parameter logic [6:0]  CFG_RESET     = 7'h00
) (
    input  logic       clock_160,
    input  logic       resn,
    input  logic       req_valid,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic [6:0] cfg,
    output logic       sw_res,
    output logic       busy
);

`ifdef CLKSEQ_SETTLE_EN
    localparam int unsigned CntMax = (SETTLE_CYCLES > RESET_CYCLES) ? SETTLE_CYCLES : RESET_CYCLES;
`else
    localparam int unsigned CntMax = RESET_CYCLES;
`endif
    localparam int unsigned CntW = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] ResetLoad = CntW'(RESET_CYCLES - 1);

    clkseq_state_t   state_q;
    logic [7:0]      nxt_q;
    logic [6:0]      cfg_q;
    logic            pend_q;
    logic            sw_res_q;
    logic            busy_q;
    logic            ready_q;
    logic [1:0]      rise;
    logic            tmr_load;
    logic [CntW-1:0] tmr_val;
    logic            tmr_dec;
    logic            tmr_zero;

`ifdef CLKSEQ_SETTLE_EN
    localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);

    assign rise = nxt_q[CLK_PLLENA:CLK_OSCENA] & ~cfg_q[CLK_PLLENA:CLK_OSCENA];

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = ResetLoad;
        if (state_q == ENABLE) begin
            tmr_load = 1'b1;
            tmr_val  = SettleLoad;
        end else if ((state_q == APPLY) && nxt_q[CLK_RESET]) begin
            tmr_load = 1'b1;
        end
    end
`else
    assign rise = 2'b00;

    always_comb begin
        tmr_load = (state_q == APPLY) && nxt_q[CLK_RESET];
        tmr_val  = ResetLoad;
    end
`endif

    assign tmr_dec = (state_q == SETTLE) || (state_q == RESET);

    clkseq_timer #(
        .Width (CntW)
    ) u_timer (
        .clk_i      (clock_160),
        .rst_ni     (resn),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    // The accepted request is registered first; rise is judged from nxt_q a cycle later.
    always_ff @(posedge clock_160 or negedge resn) begin
        if (!resn) begin
            state_q  <= IDLE;
            nxt_q    <= 8'h00;
            cfg_q    <= CFG_RESET;
            pend_q   <= 1'b0;
            sw_res_q <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pend_q) begin
                        pend_q  <= 1'b0;
                        state_q <= (rise != 2'b00) ? ENABLE : APPLY;
                    end else if (req_valid && ready_q) begin
                        nxt_q   <= req_data;
                        pend_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                ENABLE: begin
                    cfg_q   <= {nxt_q[CLK_PLLENA:CLK_OSCM_LO], cfg_q[CLK_SEL_HI:CLK_SEL_LO]};
                    state_q <= SETTLE;
                end
                SETTLE: begin
                    if (tmr_zero) begin
                        state_q <= APPLY;
                    end
                end
                APPLY: begin
                    cfg_q <= nxt_q[6:0];
                    if (nxt_q[CLK_RESET]) begin
                        state_q  <= RESET;
                        sw_res_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                RESET: begin
                    if (tmr_zero) begin
                        state_q  <= IDLE;
                        sw_res_q <= 1'b0;
                        busy_q   <= 1'b0;
                        ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    sw_res_q <= 1'b0;
                    busy_q   <= 1'b0;
                    ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign cfg       = cfg_q;
    assign sw_res    = sw_res_q;
    assign busy      = busy_q;

endmodule
